// File: rtl/operand_select_stage_if.sv
// rtl/operand_select_stage_if.sv - handshake and operand bus for operand_select_stage
interface operand_select_stage_if #(
    parameter int IN_W    = 16,
    parameter int OUT_W   = 32,
    parameter int NUM_SRC = 4
);
    localparam int SEL_W = $clog2(NUM_SRC);

    logic                     in_valid;
    logic                     in_ready;
    logic [NUM_SRC*OUT_W-1:0] src_flat;
    logic [SEL_W-1:0]         sel_a;
    logic [SEL_W-1:0]         sel_b;
    logic                     use_imm;
    logic [IN_W-1:0]          imm;
    logic [1:0]               ext_mode;
    logic                     out_valid;
    logic                     out_ready;
    logic [OUT_W-1:0]         out_a;
    logic [OUT_W-1:0]         out_b;
    logic [15:0]              xfer_cnt;
    logic                     sel_err;

    // Producer/consumer side surrounding the stage
    modport master (
        output in_valid, src_flat, sel_a, sel_b, use_imm, imm, ext_mode, out_ready,
        input  in_ready, out_valid, out_a, out_b, xfer_cnt, sel_err
    );

    // The stage itself
    modport slave (
        input  in_valid, src_flat, sel_a, sel_b, use_imm, imm, ext_mode, out_ready,
        output in_ready, out_valid, out_a, out_b, xfer_cnt, sel_err
    );
endinterface

// File: rtl/operand_select_stage.sv
// rtl/operand_select_stage.sv - operand select/extend stage with 2-entry skid buffer; optional OPSEL_SELERR_EN
module operand_select_stage #(
    parameter int IN_W    = 16,
    parameter int OUT_W   = 32,
    parameter int NUM_SRC = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    operand_select_stage_if.slave  bus
);
    logic [OUT_W-1:0] imm_ext;
    logic [OUT_W-1:0] a_val;
    logic [OUT_W-1:0] b_src;
    logic [OUT_W-1:0] b_val;

    logic             main_valid;
    logic [OUT_W-1:0] main_a;
    logic [OUT_W-1:0] main_b;
    logic             skid_valid;
    logic [OUT_W-1:0] skid_a;
    logic [OUT_W-1:0] skid_b;
    logic             in_ready_r;
    logic [15:0]      xfer_cnt_r;
    logic             in_fire;
    logic             out_fire;

    generate
        if (IN_W == OUT_W) begin : g_full
            // Immediate already fills the operand; every mode passes it through
            assign imm_ext = bus.imm;
        end else begin : g_ext
            // Immediate extension; reserved mode falls back to sign extension
            always_comb begin
                case (bus.ext_mode)
                    2'b01:   imm_ext = {{(OUT_W-IN_W){1'b0}}, bus.imm};
                    2'b10:   imm_ext = {bus.imm, {(OUT_W-IN_W){1'b0}}};
                    default: imm_ext = {{(OUT_W-IN_W){bus.imm[IN_W-1]}}, bus.imm};
                endcase
            end
        end
    endgenerate

    // Source muxes; an out-of-range select matches no source and yields zero
    always_comb begin
        a_val = '0;
        b_src = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (int'(bus.sel_a) == k) a_val = bus.src_flat[k*OUT_W +: OUT_W];
            if (int'(bus.sel_b) == k) b_src = bus.src_flat[k*OUT_W +: OUT_W];
        end
    end

    assign b_val    = bus.use_imm ? imm_ext : b_src;
    assign in_fire  = bus.in_valid && in_ready_r;
    assign out_fire = main_valid && bus.out_ready;

    // Skid buffer: main drives the outputs, skid catches a beat while main is held
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            main_a     <= '0;
            main_b     <= '0;
            skid_valid <= 1'b0;
            skid_a     <= '0;
            skid_b     <= '0;
            in_ready_r <= 1'b1;
            xfer_cnt_r <= '0;
        end else begin
            if (out_fire) xfer_cnt_r <= xfer_cnt_r + 16'd1;
            if (skid_valid) begin
                // in_ready is low here, so only draining can happen
                if (out_fire) begin
                    main_a     <= skid_a;
                    main_b     <= skid_b;
                    skid_valid <= 1'b0;
                    in_ready_r <= 1'b1;
                end
            end else if (in_fire) begin
                if (!main_valid || out_fire) begin
                    main_valid <= 1'b1;
                    main_a     <= a_val;
                    main_b     <= b_val;
                end else begin
                    skid_valid <= 1'b1;
                    skid_a     <= a_val;
                    skid_b     <= b_val;
                    in_ready_r <= 1'b0;
                end
            end else if (out_fire) begin
                main_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = main_valid;
    assign bus.out_a     = main_a;
    assign bus.out_b     = main_b;
    assign bus.xfer_cnt  = xfer_cnt_r;

`ifdef OPSEL_SELERR_EN
    logic sel_err_r;
    logic sel_bad;

    assign sel_bad = (int'(bus.sel_a) >= NUM_SRC) ||
                     (!bus.use_imm && (int'(bus.sel_b) >= NUM_SRC));

    // Sticky flag for any accepted beat carrying an out-of-range select
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_err_r <= 1'b0;
        end else if (in_fire && sel_bad) begin
            sel_err_r <= 1'b1;
        end
    end

    assign bus.sel_err = sel_err_r;
`else
    assign bus.sel_err = 1'b0;
`endif
endmodule
